// File: rtl/sbox_sub_engine_if.sv
// sbox_sub_engine_if: word intake and result handshake bundle for sbox_sub_engine
// Signals: in_valid/in_ready/in_inv/in_data carry the word and its direction in,
//   out_valid/out_ready/out_data carry the substituted word out, busy flags work in progress.
// Modports: master = producer/consumer side, slave = engine side.
interface sbox_sub_engine_if #(
    parameter int NBYTES = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_inv;
    logic [8*NBYTES-1:0]   in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [8*NBYTES-1:0]   out_data;
    logic                  busy;

    modport master (
        output in_valid, in_inv, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_inv, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/sbox_sub_engine.sv
// sbox_sub_engine: iterative AES SubBytes/InvSubBytes over an NBYTES word, NSBOX bytes per cycle
// Ports: CLK rising-edge clock, RST_N asynchronous active-low reset,
//   io (sbox_sub_engine_if.slave): in_* word intake (in_inv=1 selects inverse S-box),
//   out_* registered result held until out_ready, busy high while beats are processed.
module sbox_sub_engine #(
    parameter int NBYTES = 16,
    parameter int NSBOX  = 4
) (
    input logic              CLK,
    input logic              RST_N,
    sbox_sub_engine_if.slave io
);
    localparam int W     = 8 * NBYTES;
    localparam int SW    = 8 * NSBOX;
    localparam int BEATS = NBYTES / NSBOX;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

    if (NSBOX < 1 || NSBOX > NBYTES || (NBYTES % NSBOX) != 0) begin : g_bad_param
        $error("sbox_sub_engine: NSBOX must divide NBYTES and lie in 1..NBYTES");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [W-1:0]  work_q, work_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic          inv_q, inv_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] sb_in, sb_out;
    logic          accept;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? (p ^ x) : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; 0 maps to 0 naturally
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a3, a7, a15, a31, a63, a127;
        a3   = gf_mul(gf_mul(a, a), a);
        a7   = gf_mul(gf_mul(a3, a3), a);
        a15  = gf_mul(gf_mul(a7, a7), a);
        a31  = gf_mul(gf_mul(a15, a15), a);
        a63  = gf_mul(gf_mul(a31, a31), a);
        a127 = gf_mul(gf_mul(a63, a63), a);
        return gf_mul(a127, a127);
    endfunction

    function automatic logic [7:0] aff_fwd(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] aff_inv(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    assign sb_in = work_q[int'(beat_q) * SW +: SW];

    for (genvar k = 0; k < NSBOX; k++) begin : g_sbox
        logic [7:0] b;
        assign b = sb_in[8*k +: 8];
        assign sb_out[8*k +: 8] = inv_q ? gf_inv(aff_inv(b)) : aff_fwd(gf_inv(b));
    end

    assign io.in_ready  = (state_q == IDLE) || (state_q == DONE && io.out_ready);
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign io.busy      = (state_q == BUSY);
    assign accept       = io.in_valid && io.in_ready;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        work_d      = work_q;
        inv_d       = inv_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            IDLE: ;
            BUSY: begin
                work_d[int'(beat_q) * SW +: SW] = sb_out;
                beat_d = beat_q + BW'(1);
                if (beat_q == LAST) begin
                    state_d     = DONE;
                    beat_d      = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = work_d;
                end
            end
            DONE: begin
                if (io.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                beat_d      = '0;
                out_valid_d = 1'b0;
            end
        endcase
        // Intake happens from IDLE or from DONE in the same edge the result is consumed
        if (accept) begin
            state_d = BUSY;
            beat_d  = '0;
            work_d  = io.in_data;
            inv_d   = io.in_inv;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            work_q      <= '0;
            inv_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            work_q      <= work_d;
            inv_q       <= inv_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end
endmodule

// File: tb/tb_sbox_sub_engine.sv
// tb_sbox_sub_engine: scoreboard bench for sbox_sub_engine across NSBOX = 4, 1, 2, 16
module tb_sbox_sub_engine;
    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    logic [127:0] sb_q[$];
    logic [7:0] fwd_tab[256];
    logic [7:0] inv_tab[256];

    localparam logic [127:0] FIPS_IN  = 128'h193DE3BEA0F4E22B9AC68D2AE9F84808;
    localparam logic [127:0] FIPS_OUT = 128'hD42711AEE0BF98F1B8B45DE51E415230;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    sbox_sub_engine_if #(.NBYTES(16)) io   ();
    sbox_sub_engine_if #(.NBYTES(16)) io1  ();
    sbox_sub_engine_if #(.NBYTES(16)) io2  ();
    sbox_sub_engine_if #(.NBYTES(16)) io16 ();

    sbox_sub_engine #(.NBYTES(16), .NSBOX(4))  dut   (.CLK(CLK), .RST_N(RST_N), .io(io));
    sbox_sub_engine #(.NBYTES(16), .NSBOX(1))  dut1  (.CLK(CLK), .RST_N(RST_N), .io(io1));
    sbox_sub_engine #(.NBYTES(16), .NSBOX(2))  dut2  (.CLK(CLK), .RST_N(RST_N), .io(io2));
    sbox_sub_engine #(.NBYTES(16), .NSBOX(16)) dut16 (.CLK(CLK), .RST_N(RST_N), .io(io16));

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Schoolbook product then polynomial reduction, independent of the shift-reduce form
    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_tables();
        logic [7:0] v, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            v = 8'h00;
            for (int y = 1; y < 256; y++) if (tb_mul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8] ^ v[(i+6)%8] ^ v[(i+7)%8] ^ c[i];
            fwd_tab[x] = s;
            inv_tab[s] = 8'(x);
        end
    endtask

    // Literals are written byte 0 first; the bus puts byte 0 in the low bits
    function automatic logic [127:0] rev(input logic [127:0] w);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = w[8*(15-i) +: 8];
        return r;
    endfunction

    function automatic logic [127:0] sub_word(input logic [127:0] w, input logic inv);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = inv ? inv_tab[w[8*i +: 8]] : fwd_tab[w[8*i +: 8]];
        return r;
    endfunction

    task automatic send(input logic [127:0] d, input logic inv, input logic [127:0] exp);
        int n = 0;
        while (io.in_ready !== 1'b1 && n < 64) begin
            @(negedge CLK);
            n++;
        end
        check("send_ready", io.in_ready, 1);
        io.in_valid = 1'b1;
        io.in_data  = d;
        io.in_inv   = inv;
        sb_q.push_back(exp);
        @(negedge CLK);
        acc_cyc     = cyc;
        io.in_valid = 1'b0;
        io.in_data  = ~d;
        io.in_inv   = ~inv;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (io.out_valid !== 1'b1 && n < 64) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_valid"}, io.out_valid, 1);
    endtask

    task automatic recv(input string tag, input int exp_lat, output logic [127:0] got);
        logic [127:0] exp;
        wait_valid(tag);
        if (exp_lat >= 0) check({tag, "_lat"}, 128'(cyc - acc_cyc), 128'(exp_lat));
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
        got = io.out_data;
        check({tag, "_data"}, got, exp);
        io.out_ready = 1'b1;
        @(negedge CLK);
        io.out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] w, got, wa, wb;
        logic [127:0] d1, d2, d16;
        int lat1, lat2, lat16, seen;
        io.in_valid = 0;   io.in_inv = 0;   io.in_data = '0;   io.out_ready = 0;
        io1.in_valid = 0;  io1.in_inv = 0;  io1.in_data = '0;  io1.out_ready = 1;
        io2.in_valid = 0;  io2.in_inv = 0;  io2.in_data = '0;  io2.out_ready = 1;
        io16.in_valid = 0; io16.in_inv = 0; io16.in_data = '0; io16.out_ready = 1;
        build_tables();
        repeat (3) @(negedge CLK);
        check("reset_out_valid", io.out_valid, 0);
        check("reset_out_data", io.out_data, 0);
        check("reset_busy", io.busy, 0);
        check("reset_in_ready", io.in_ready, 1);
        RST_N = 1'b1;
        @(negedge CLK);

        w = {$urandom, $urandom, $urandom, 32'h01FF5300};
        send(w, 1'b0, sub_word(w, 1'b0));
        check("t1_busy", io.busy, 1);
        check("t1_in_ready_busy", io.in_ready, 0);
        recv("t1", 4, got);
        check("t1_low_bytes", got[31:0], 32'h7C16ED63);

        send(rev(FIPS_IN), 1'b0, rev(FIPS_OUT));
        recv("fips_fwd", 4, got);
        send(got, 1'b1, rev(FIPS_IN));
        recv("fips_inv", 4, got);

        w = {$urandom, $urandom, $urandom, 32'h7C160063};
        send(w, 1'b1, sub_word(w, 1'b1));
        recv("inv_spot", 4, got);
        check("inv_spot_low_bytes", got[31:0], 32'h01FF5200);

        for (int j = 0; j < 16; j++) begin
            for (int i = 0; i < 16; i++) w[8*i +: 8] = 8'(16*j + i);
            send(w, 1'b0, sub_word(w, 1'b0));
            recv("sweep_fwd", 4, got);
            send(got, 1'b1, w);
            recv("sweep_inv", 4, got);
        end

        wa = {$urandom, $urandom, $urandom, $urandom};
        wb = {$urandom, $urandom, $urandom, $urandom};
        send(wa, 1'b0, sub_word(wa, 1'b0));
        wait_valid("bp_first");
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_valid", io.out_valid, 1);
            check("bp_hold_data", io.out_data, sb_q[0]);
            check("bp_hold_in_ready", io.in_ready, 0);
            @(negedge CLK);
        end
        io.out_ready = 1'b1;
        io.in_valid  = 1'b1;
        io.in_data   = wb;
        io.in_inv    = 1'b1;
        #1;
        check("bp_in_ready_follows_out_ready", io.in_ready, 1);
        check("bp_data_at_handshake", io.out_data, sb_q.pop_front());
        sb_q.push_back(sub_word(wb, 1'b1));
        @(negedge CLK);
        acc_cyc      = cyc;
        io.in_valid  = 1'b0;
        io.out_ready = 1'b0;
        check("bp_overlap_busy", io.busy, 1);
        check("bp_overlap_valid_drop", io.out_valid, 0);
        recv("bp_next", 4, got);

        w = {$urandom, $urandom, $urandom, $urandom};
        send(w, 1'b0, sub_word(w, 1'b0));
        @(negedge CLK);
        @(negedge CLK);
        check("rst_busy_before", io.busy, 1);
        RST_N = 1'b0;
        #1;
        check("rst_out_valid", io.out_valid, 0);
        check("rst_out_data", io.out_data, 0);
        check("rst_busy", io.busy, 0);
        sb_q.delete();
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check("rst_in_ready_after_release", io.in_ready, 1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (io.out_valid === 1'b1) seen++;
        end
        check("rst_no_output", 128'(seen), 0);

        io1.in_data = rev(FIPS_IN);  io2.in_data = rev(FIPS_IN);  io16.in_data = rev(FIPS_IN);
        io1.in_valid = 1;            io2.in_valid = 1;            io16.in_valid = 1;
        check("sweep1_ready", io1.in_ready, 1);
        check("sweep2_ready", io2.in_ready, 1);
        check("sweep16_ready", io16.in_ready, 1);
        @(negedge CLK);
        acc_cyc = cyc;
        io1.in_valid = 0; io2.in_valid = 0; io16.in_valid = 0;
        lat1 = -1; lat2 = -1; lat16 = -1;
        d1 = '0;   d2 = '0;   d16 = '0;
        for (int n = 0; n < 40; n++) begin
            if (io1.out_valid === 1'b1 && lat1 < 0) begin lat1 = cyc - acc_cyc; d1 = io1.out_data; end
            if (io2.out_valid === 1'b1 && lat2 < 0) begin lat2 = cyc - acc_cyc; d2 = io2.out_data; end
            if (io16.out_valid === 1'b1 && lat16 < 0) begin lat16 = cyc - acc_cyc; d16 = io16.out_data; end
            @(negedge CLK);
        end
        check("nsbox1_lat", 128'(lat1), 16);
        check("nsbox2_lat", 128'(lat2), 8);
        check("nsbox16_lat", 128'(lat16), 1);
        check("nsbox1_data", d1, rev(FIPS_OUT));
        check("nsbox2_data", d2, rev(FIPS_OUT));
        check("nsbox16_data", d16, rev(FIPS_OUT));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
